shift_arbiter: RTL

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_pkg.sv | 35 +++
 rtl/shift_core.sv | 50 +++++
 rtl/shift_arbiter.sv | 86 ++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared types, widths and bit helpers for the shift arbiter block.
package shift_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_t;

  // Bit reversal lets left shifts reuse the right-shift mux chain.
  function automatic logic [DATA_W-1:0] bitRev(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] r;
    for (int b = 0; b < DATA_W; b++) r[b] = x[DATA_W-1-b];
    return r;
  endfunction

  // One fixed-distance right-shift stage; vacated bits take the wrapped
  // bits when rotating, otherwise the fill bit.
  function automatic logic [DATA_W-1:0] shrStage(input logic [DATA_W-1:0] x,
                                                 input int k,
                                                 input logic rot,
                                                 input logic fill);
    logic [DATA_W-1:0] r;
    for (int b = 0; b < DATA_W; b++) begin
      if (b + k < DATA_W) r[b] = x[b+k];
      else                r[b] = rot ? x[b+k-DATA_W] : fill;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_core.sv
// Combinational shifter: five-stage 16/8/4/2/1 right-shift mux chain.
// LSL runs through the same chain on the bit-reversed operand. The carry
// is the low bit dropped by the last active stage, i.e. the last bit out.
// Macro SHIFT_ROR_EN enables rotate; without it Sh=11 passes Data through.
import shift_pkg::*;

module shift_core (
  input  logic [DATA_W-1:0]  data,
  input  logic [SHAMT_W-1:0] shamt,
  input  shift_t             sh,
  output logic [DATA_W-1:0]  res,
  output logic               carry
);

  logic                      isLsl;
  logic                      rot;
  logic                      fill;
  logic [SHAMT_W-1:0]        effAmt;
  logic [SHAMT_W:0][DATA_W-1:0] stg;
  logic [SHAMT_W:0]          cy;

  // Decode shift type into chain controls.
  always_comb begin
    isLsl  = (sh == SH_LSL);
    fill   = (sh == SH_ASR) & data[DATA_W-1];
`ifdef SHIFT_ROR_EN
    rot    = (sh == SH_ROR);
    effAmt = shamt;
`else
    // No rotate hardware: Sh=11 collapses to a zero-distance shift.
    rot    = 1'b0;
    effAmt = (sh == SH_ROR) ? '0 : shamt;
`endif
  end

  assign stg[0] = isLsl ? bitRev(data) : data;
  assign cy[0]  = 1'b0;

  for (genvar i = 0; i < SHAMT_W; i++) begin : gStage
    localparam int K = 1 << (SHAMT_W - 1 - i);
    logic on;
    assign on         = effAmt[SHAMT_W-1-i];
    assign stg[i+1]   = on ? shrStage(stg[i], K, rot, fill) : stg[i];
    assign cy[i+1]    = on ? stg[i][K-1] : cy[i];
  end

  assign res   = isLsl ? bitRev(stg[SHAMT_W]) : stg[SHAMT_W];
  assign carry = cy[SHAMT_W];

endmodule

// File: rtl/shift_arbiter.sv
// Two requesters share one shifter behind a single registered response
// stage (EMPTY/FULL). Round-robin pointer picks the winner when both are
// valid and moves to the loser after every accept. Optional rotate is
// controlled by macro SHIFT_ROR_EN inside shift_core.
import shift_pkg::*;

module shift_arbiter #(
  parameter int RR_INIT = 0
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               Req0Valid,
  input  logic               Req1Valid,
  output logic               Req0Ready,
  output logic               Req1Ready,
  input  logic [DATA_W-1:0]  Req0Data,
  input  logic [DATA_W-1:0]  Req1Data,
  input  logic [SHAMT_W-1:0] Req0Shamt,
  input  logic [SHAMT_W-1:0] Req1Shamt,
  input  logic [1:0]         Req0Sh,
  input  logic [1:0]         Req1Sh,
  output logic               RspValid,
  input  logic               RspReady,
  output logic [DATA_W-1:0]  RspData,
  output logic               RspCarry,
  output logic               RspId
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              state;
  logic                rrPtr;
  logic                canAccept;
  logic                grant0;
  logic                grant1;
  logic                accept;
  logic [DATA_W-1:0]   selData;
  logic [SHAMT_W-1:0]  selShamt;
  shift_t              selSh;
  logic [DATA_W-1:0]   coreRes;
  logic                coreCarry;

  // Grant: slot free (or draining this cycle), then round-robin tie-break.
  always_comb begin
    canAccept = ~Reset & ((state == EMPTY) | RspReady);
    grant0    = canAccept & Req0Valid & (~Req1Valid | (rrPtr == 1'b0));
    grant1    = canAccept & Req1Valid & (~Req0Valid | (rrPtr == 1'b1));
    accept    = grant0 | grant1;
    selData   = grant1 ? Req1Data  : Req0Data;
    selShamt  = grant1 ? Req1Shamt : Req0Shamt;
    selSh     = shift_t'(grant1 ? Req1Sh : Req0Sh);
  end

  assign Req0Ready = grant0;
  assign Req1Ready = grant1;

  shift_core uCore (
    .data  (selData),
    .shamt (selShamt),
    .sh    (selSh),
    .res   (coreRes),
    .carry (coreCarry)
  );

  // Response stage FSM with registered result and priority pointer.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= EMPTY;
      RspData  <= '0;
      RspCarry <= 1'b0;
      RspId    <= 1'b0;
      rrPtr    <= 1'(RR_INIT);
    end else if (accept) begin
      state    <= FULL;
      RspData  <= coreRes;
      RspCarry <= coreCarry;
      RspId    <= grant1;
      rrPtr    <= ~grant1;
    end else if (RspReady) begin
      state    <= EMPTY;
    end
  end

  assign RspValid = (state == FULL);

endmodule
